// File: rtl/fpu_div16_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_div16_if : launch/operand/result bundle for the fpu_div16 core  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fpu_div16_if;
  logic        start;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic [15:0] fpuOut;
  logic        done;
  logic [3:0]  condCodes;   // {Z,C,N,V}

  modport master (
    output start, fpuIn1, fpuIn2,
    input  fpuOut, done, condCodes
  );

  modport slave (
    input  start, fpuIn1, fpuIn2,
    output fpuOut, done, condCodes
  );
endinterface
`default_nettype wire

// File: rtl/fpu_div16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_div16 : fixed-latency half-precision divider (restoring, RNE).  |
// | Define FPU_DIV_SUBNORM_EN for subnormal support (else flush-zero). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_div16 (
  input  logic       clock,
  input  logic       reset,
  fpu_div16_if.slave bus
);

  typedef enum logic [1:0] {
    DIV_WAIT    = 2'd0,
    DIV_SIGCOMP = 2'd1,
    DIV_NORM    = 2'd2,
    DIV_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic        zero;
    logic        inf;
    logic        nan;
    logic [6:0]  e;    // two's complement, unbiased by nothing (biased exponent)
    logic [10:0] m;
  } unp_t;

  function automatic unp_t unpack(input logic [15:0] x);
    unp_t u;
    u.nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    u.inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    u.zero = 1'b0;
    u.e    = {2'b00, x[14:10]};
    u.m    = {1'b1, x[9:0]};
    if (x[14:10] == 5'd0) begin
`ifdef FPU_DIV_SUBNORM_EN
      u.zero = (x[9:0] == 10'd0);
      u.m    = {1'b0, x[9:0]};
      u.e    = 7'd1;
      for (int i = 0; i < 10; i++) begin
        if (!u.m[10]) begin
          u.m = {u.m[9:0], 1'b0};
          u.e = u.e - 7'd1;
        end
      end
`else
      u.zero = 1'b1;
      u.m    = 11'd0;
      u.e    = 7'd0;
`endif
    end
    return u;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [11:0] rem_q, rem_d;
  logic [10:0] div_q, div_d;
  logic [12:0] quo_q, quo_d;
  logic [15:0] out_q, out_d;
  logic [3:0]  cc_q, cc_d;

  unp_t        w_ua, w_ub;
  logic        w_ge;
  logic [10:0] w_rem_sub;

  assign w_ua      = unpack(a_q);
  assign w_ub      = unpack(b_q);
  assign w_ge      = (rem_q >= {1'b0, div_q});
  // Remainder stays below the divisor after a step, so 11 bits hold it before the shift.
  assign w_rem_sub = w_ge ? 11'(rem_q - {1'b0, div_q}) : rem_q[10:0];

  logic        w_sign, w_sticky, w_grd, w_rnd, w_inc, w_inexact;
  logic [10:0] w_mant;
  logic [11:0] w_mant_rnd;
  logic [6:0]  w_exp, w_exp_rnd;
  logic [9:0]  w_frac;
  logic [15:0] w_res;
  logic [3:0]  w_cc;

`ifdef FPU_DIV_SUBNORM_EN
  logic [6:0]  w_shamt;
  logic [38:0] w_wide;
  logic [10:0] w_sub_m, w_sub_rnd;
  logic        w_sub_g, w_sub_r, w_sub_s, w_sub_inc;

  always_comb begin
    w_shamt   = 7'd1 - w_exp;
    w_wide    = {w_mant, w_grd, w_rnd, 26'd0} >> w_shamt;
    w_sub_m   = w_wide[38:28];
    w_sub_g   = w_wide[27];
    w_sub_r   = w_wide[26];
    w_sub_s   = w_sticky | (|w_wide[25:0]);
    w_sub_inc = w_sub_g & (w_sub_r | w_sub_s | w_sub_m[0]);
    w_sub_rnd = w_sub_m + {10'd0, w_sub_inc};
  end
`endif

  always_comb begin
    w_sign   = a_q[15] ^ b_q[15];
    w_sticky = |rem_q;
    if (quo_q[12]) begin
      w_mant = quo_q[12:2];
      w_grd  = quo_q[1];
      w_rnd  = quo_q[0];
      w_exp  = w_ua.e - w_ub.e + 7'd15;
    end else begin
      w_mant = quo_q[11:1];
      w_grd  = quo_q[0];
      w_rnd  = 1'b0;
      w_exp  = w_ua.e - w_ub.e + 7'd14;
    end
    w_inexact  = w_grd | w_rnd | w_sticky;
    w_inc      = w_grd & (w_rnd | w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {11'd0, w_inc};
    w_exp_rnd  = w_exp + {6'd0, w_mant_rnd[11]};
    w_frac     = w_mant_rnd[11] ? w_mant_rnd[10:1] : w_mant_rnd[9:0];

    w_res = {w_sign, w_exp_rnd[4:0], w_frac};
    w_cc  = {1'b0, w_inexact, w_sign, 1'b0};
    if ($signed(w_exp_rnd) >= 7'sd31) begin
      w_res = {w_sign, 5'h1F, 10'd0};
      w_cc  = {2'b00, w_sign, 1'b1};
    end
`ifdef FPU_DIV_SUBNORM_EN
    else if ($signed(w_exp) <= 7'sd0) begin
      // A rounding carry into bit 10 lands naturally in the exponent LSB.
      w_res = {w_sign, 4'd0, w_sub_rnd};
      w_cc  = {(w_sub_rnd == 11'd0), (w_sub_g | w_sub_r | w_sub_s), w_sign, 1'b0};
    end
`else
    else if ($signed(w_exp_rnd) <= 7'sd0) begin
      w_res = {w_sign, 15'd0};
      w_cc  = {1'b1, 1'b1, w_sign, 1'b0};
    end
`endif

    if (w_ua.nan || w_ub.nan || (w_ua.inf && w_ub.inf) || (w_ua.zero && w_ub.zero)) begin
      w_res = 16'h7E00;
      w_cc  = 4'b0000;
    end else if (w_ua.inf) begin
      w_res = {w_sign, 5'h1F, 10'd0};
      w_cc  = {2'b00, w_sign, 1'b0};
    end else if (w_ub.inf || w_ua.zero) begin
      w_res = {w_sign, 15'd0};
      w_cc  = {1'b1, 1'b0, w_sign, 1'b0};
    end else if (w_ub.zero) begin
      w_res = {w_sign, 5'h1F, 10'd0};
      w_cc  = {2'b00, w_sign, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    out_d   = out_q;
    cc_d    = cc_q;
    unique case (state_q)
      DIV_WAIT, DIV_DONE: begin
        if (bus.start) begin
          state_d = DIV_SIGCOMP;
          a_d     = bus.fpuIn1;
          b_d     = bus.fpuIn2;
          cnt_d   = 4'd0;
        end
      end
      DIV_SIGCOMP: begin
        cnt_d = cnt_q + 4'd1;
        // Count 0 loads the significands; counts 1..13 each retire one quotient bit.
        if (cnt_q == 4'd0) begin
          rem_d = {1'b0, w_ua.m};
          div_d = w_ub.m;
          quo_d = 13'd0;
        end else begin
          rem_d = {w_rem_sub, 1'b0};
          quo_d = {quo_q[11:0], w_ge};
        end
        if (cnt_q == 4'd13) begin
          state_d = DIV_NORM;
        end
      end
      DIV_NORM: begin
        state_d = DIV_DONE;
        out_d   = w_res;
        cc_d    = w_cc;
        cnt_d   = 4'd0;
      end
      default: state_d = DIV_WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DIV_WAIT;
      cnt_q   <= 4'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      rem_q   <= 12'd0;
      div_q   <= 11'd0;
      quo_q   <= 13'd0;
      out_q   <= 16'h0000;
      cc_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
      cc_q    <= cc_d;
    end
  end

  assign bus.fpuOut    = out_q;
  assign bus.condCodes = cc_q;
  assign bus.done      = (state_q == DIV_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_div16.sv
`default_nettype none
// Directed self-checking bench for fpu_div16.
module tb_fpu_div16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fpu_div16_if bus ();

  fpu_div16 dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Launch one divide and count rising edges until done; 0 means it never came.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    bus.fpuIn1 = a;
    bus.fpuIn2 = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.fpuIn1 = 16'($urandom);
    bus.fpuIn2 = 16'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.fpuIn1 = 16'h0000;
    bus.fpuIn2 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++;
    if (bus.fpuOut !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h want 0000", bus.fpuOut); end
    n_checks++;
    if (bus.condCodes !== 4'b0000) begin n_fail++; $display("FAIL reset_cc: got %b want 0000", bus.condCodes); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // {a, b, expected quotient, expected {Z,C,N,V}}
  task automatic test_table(input string name, input logic [51:0] vecs [], input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic [51:0] v;
      v = vecs[i];
      run_op(v[51:36], v[35:20], lat);
      n_checks++;
      if (lat !== 15) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d want 15", name, i, lat); end
      n_checks++;
      if (bus.fpuOut !== v[19:4]) begin
        n_fail++; $display("FAIL %s_out[%0d] %h/%h: got %h want %h", name, i, v[51:36], v[35:20], bus.fpuOut, v[19:4]);
      end
      n_checks++;
      if (bus.condCodes !== v[3:0]) begin
        n_fail++; $display("FAIL %s_cc[%0d] %h/%h: got %b want %b", name, i, v[51:36], v[35:20], bus.condCodes, v[3:0]);
      end
    end
  endtask

  task automatic test_arith();
    logic [51:0] vecs [];
    vecs = new[5];
    vecs[0] = {16'h4600, 16'h4000, 16'h4200, 4'b0000};  // 6/2
    vecs[1] = {16'h3C00, 16'h4200, 16'h3555, 4'b0100};  // 1/3, truncated
    vecs[2] = {16'hC500, 16'h4000, 16'hC100, 4'b0010};  // -5/2
    vecs[3] = {16'h4500, 16'h4200, 16'h3EAB, 4'b0100};  // 5/3, rounds up
    vecs[4] = {16'h4000, 16'h4200, 16'h3955, 4'b0100};  // 2/3
    test_table("arith", vecs, 5);
  endtask

  task automatic test_specials();
    logic [51:0] vecs [];
    vecs = new[8];
    vecs[0] = {16'hBC00, 16'h0000, 16'hFC00, 4'b0011};  // -1/0
    vecs[1] = {16'h0000, 16'h0000, 16'h7E00, 4'b0000};  // 0/0
    vecs[2] = {16'h7BFF, 16'h3800, 16'h7C00, 4'b0001};  // overflow
    vecs[3] = {16'h7C01, 16'h3C00, 16'h7E00, 4'b0000};  // NaN in
    vecs[4] = {16'h7C00, 16'hFC00, 16'h7E00, 4'b0000};  // inf/inf
    vecs[5] = {16'hFC00, 16'h4000, 16'hFC00, 4'b0010};  // -inf/2
    vecs[6] = {16'h4000, 16'h7C00, 16'h0000, 4'b1000};  // 2/inf
    vecs[7] = {16'h8000, 16'h4200, 16'h8000, 4'b1010};  // -0/3
    test_table("special", vecs, 8);
  endtask

  task automatic test_subnormal();
    logic [51:0] vecs [];
    vecs = new[1];
`ifdef FPU_DIV_SUBNORM_EN
    vecs[0] = {16'h0001, 16'h3C00, 16'h0001, 4'b0000};
`else
    vecs[0] = {16'h0001, 16'h3C00, 16'h0000, 4'b1000};
`endif
    test_table("subnorm", vecs, 1);
  endtask

  task automatic test_hold();
    int lat;
    int bad_done;
    int bad_out;
    run_op(16'h4600, 16'h4000, lat);
    bad_done = 0;
    bad_out  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b1) bad_done++;
      if (bus.fpuOut !== 16'h4200 || bus.condCodes !== 4'b0000) bad_out++;
    end
    n_checks++;
    if (bad_done !== 0) begin n_fail++; $display("FAIL hold_done: got %0d low cycles want 0", bad_done); end
    n_checks++;
    if (bad_out !== 0) begin n_fail++; $display("FAIL hold_out: got %0d changed cycles want 0", bad_out); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16'h3C00, 16'h4200, lat);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL b2b_latency: got %0d want 15", lat); end
    n_checks++;
    if (bus.fpuOut !== 16'h3555) begin n_fail++; $display("FAIL b2b_out: got %h want 3555", bus.fpuOut); end
    n_checks++;
    if (bus.condCodes !== 4'b0100) begin n_fail++; $display("FAIL b2b_cc: got %b want 0100", bus.condCodes); end
  endtask

  task automatic test_reset_midop();
    int lat;
    int bad_done;
    int bad_out;
    @(negedge clk);
    bus.fpuIn1 = 16'h4600;
    bus.fpuIn2 = 16'h4000;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bad_done = 0;
    bad_out  = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) bad_done++;
      if (bus.fpuOut !== 16'h0000) bad_out++;
    end
    n_checks++;
    if (bad_done !== 0) begin n_fail++; $display("FAIL abort_done: got %0d high cycles want 0", bad_done); end
    n_checks++;
    if (bad_out !== 0) begin n_fail++; $display("FAIL abort_out: got %0d nonzero cycles want 0", bad_out); end
    run_op(16'h4600, 16'h4000, lat);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL abort_relaunch_latency: got %0d want 15", lat); end
    n_checks++;
    if (bus.fpuOut !== 16'h4200) begin n_fail++; $display("FAIL abort_relaunch_out: got %h want 4200", bus.fpuOut); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_hold();
    test_back_to_back();
    test_specials();
    test_subnormal();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
